// File: rtl/hist_pkg.sv
// Shared definitions for the frame histogram controller: FSM state encoding
// and default pixel / counter widths.
package hist_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 18;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_DUMP_RD,
        ST_DUMP_OUT
    } state_e;

endpackage

// File: rtl/hist_rmw_pipe.sv
// Accumulate read-modify-write pipe for the histogram RAM.
// The bin read is issued by the top in the pixel cycle. One cycle later the
// incremented, saturating count is written back.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_en, i_pix   accepted pixel and its bin index (read issued this cycle)
//   i_rd_data     RAM read data for the pixel accepted last cycle
//   o_we, o_wr_addr, o_wr_data   write-back request
//   o_sat         write-back hit the counter ceiling
module hist_rmw_pipe
    import hist_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_pix,
    input  logic [CNT_WIDTH-1:0]  i_rd_data,
    output logic                  o_we,
    output logic [DATA_WIDTH-1:0] o_wr_addr,
    output logic [CNT_WIDTH-1:0]  o_wr_data,
    output logic                  o_sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_pix;
    logic                  r_fwd_vld;
    logic [DATA_WIDTH-1:0] r_fwd_addr;
    logic [CNT_WIDTH-1:0]  r_fwd_data;

    logic [CNT_WIDTH-1:0]  w_base;
    logic [CNT_WIDTH-1:0]  w_new;
    logic                  w_max;

    // The read for r_pix was sampled on the same edge that committed the
    // previous write-back, so the RAM returns the pre-write value. If both
    // target the same bin, take the value just written instead.
    assign w_base = (r_fwd_vld && (r_fwd_addr == r_pix)) ? r_fwd_data : i_rd_data;
    assign w_max  = &w_base;
    assign w_new  = w_max ? w_base : (w_base + CNT_ONE);

    assign o_we      = r_vld;
    assign o_wr_addr = r_pix;
    assign o_wr_data = w_new;
    assign o_sat     = r_vld && w_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= 1'b0;
            r_pix      <= '0;
            r_fwd_vld  <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
        end else begin
            r_vld      <= i_en;
            r_pix      <= i_pix;
            r_fwd_vld  <= r_vld;
            r_fwd_addr <= r_pix;
            r_fwd_data <= w_new;
        end
    end

endmodule

// File: rtl/hist_frame_ctrl.sv
// Frame histogram controller: clears the bin RAM, accumulates one frame of
// pixels, then streams every bin out (clearing it behind the readout).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   VSYNC, DataEn, PixelData            video input
//   ram_rd_addr / ram_rd_data           RAM read port (1-cycle latency)
//   ram_we, ram_wr_addr, ram_wr_data    RAM write port
//   hist_valid/ready/bin/count/last     readout stream
//   busy, sat_flag, pixel_drop, frame_overrun   status
module hist_frame_ctrl
    import hist_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  VSYNC,
    input  logic                  DataEn,
    input  logic [DATA_WIDTH-1:0] PixelData,
    output logic [DATA_WIDTH-1:0] ram_rd_addr,
    input  logic [CNT_WIDTH-1:0]  ram_rd_data,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wr_addr,
    output logic [CNT_WIDTH-1:0]  ram_wr_data,
    output logic                  hist_valid,
    input  logic                  hist_ready,
    output logic [DATA_WIDTH-1:0] hist_bin,
    output logic [CNT_WIDTH-1:0]  hist_count,
    output logic                  hist_last,
    output logic                  busy,
    output logic                  sat_flag,
    output logic                  pixel_drop,
    output logic                  frame_overrun
);

    localparam logic [DATA_WIDTH-1:0] BIN_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                r_state, w_state_nx;
    logic [DATA_WIDTH-1:0] r_bin, w_bin_nx;
    logic                  r_vsync_d;
    logic                  r_busy;
    logic                  r_sat;
    logic                  r_held;
    logic [CNT_WIDTH-1:0]  r_hold_cnt;

    logic                  w_vs_rise;
    logic                  w_accum;
    logic                  w_last_bin;
    logic                  w_hs;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic                  w_pipe_we;
    logic [DATA_WIDTH-1:0] w_pipe_addr;
    logic [CNT_WIDTH-1:0]  w_pipe_data;
    logic                  w_pipe_sat;

    assign w_accum    = (r_state == ST_ACCUM);
    assign w_vs_rise  = VSYNC && !r_vsync_d;
    assign w_last_bin = &r_bin;
    assign hist_valid = (r_state == ST_DUMP_OUT);
    assign w_hs       = hist_valid && hist_ready;

    hist_rmw_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_rmw (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (DataEn && w_accum),
        .i_pix     (PixelData),
        .i_rd_data (ram_rd_data),
        .o_we      (w_pipe_we),
        .o_wr_addr (w_pipe_addr),
        .o_wr_data (w_pipe_data),
        .o_sat     (w_pipe_sat)
    );

    always_comb begin
        w_state_nx = r_state;
        w_bin_nx   = r_bin;
        case (r_state)
            ST_CLEAR: begin
                w_bin_nx = r_bin + BIN_ONE;
                if (w_last_bin) w_state_nx = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_vs_rise) w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_nx = ST_DUMP_RD;
                w_bin_nx   = '0;
            end
            ST_DUMP_RD: begin
                w_state_nx = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (w_hs) begin
                    w_bin_nx   = r_bin + BIN_ONE;
                    w_state_nx = w_last_bin ? ST_ACCUM : ST_DUMP_RD;
                end
            end
            default: begin
                w_state_nx = ST_CLEAR;
                w_bin_nx   = '0;
            end
        endcase
    end

    // Write port: the pending accumulate write-back always wins (it can only
    // land in ACCUM or DRAIN); otherwise zero the current bin while clearing
    // or once the readout of that bin is accepted.
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = r_bin;
        ram_wr_data = '0;
        if (w_pipe_we) begin
            ram_we      = 1'b1;
            ram_wr_addr = w_pipe_addr;
            ram_wr_data = w_pipe_data;
        end else if (r_state == ST_CLEAR) begin
            // State sits in CLEAR while reset is held; keep the port quiet then.
            ram_we = rst_n;
        end else if (w_hs) begin
            ram_we = 1'b1;
        end
    end

    assign ram_rd_addr = w_accum ? PixelData : r_bin;

    // Once a bin has been presented, hold its count locally so a stall does
    // not depend on the RAM output staying put.
    assign w_cnt      = r_held ? r_hold_cnt : ram_rd_data;
    assign hist_bin   = hist_valid ? r_bin : '0;
    assign hist_count = hist_valid ? w_cnt : '0;
    assign hist_last  = hist_valid && w_last_bin;

    assign busy          = r_busy;
    assign sat_flag      = r_sat;
    assign pixel_drop    = rst_n && DataEn && !w_accum;
    assign frame_overrun = rst_n && w_vs_rise && !w_accum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_bin      <= '0;
            r_vsync_d  <= 1'b0;
            r_busy     <= 1'b0;
            r_sat      <= 1'b0;
            r_held     <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_bin     <= w_bin_nx;
            r_vsync_d <= VSYNC;
            r_busy    <= (w_state_nx != ST_ACCUM);
            if ((w_state_nx == ST_ACCUM) && !w_accum) r_sat <= 1'b0;
            else if (w_pipe_sat)                      r_sat <= 1'b1;
            r_held <= hist_valid && !hist_ready;
            if (hist_valid) r_hold_cnt <= w_cnt;
        end
    end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
module tb_hist_frame_ctrl;

    logic        clk;
    logic        rst_n;
    logic        VSYNC;
    logic        DataEn;
    logic [7:0]  PixelData;
    logic [7:0]  ram_rd_addr;
    logic [17:0] ram_rd_data;
    logic        ram_we;
    logic [7:0]  ram_wr_addr;
    logic [17:0] ram_wr_data;
    logic        hist_valid;
    logic        hist_ready;
    logic [7:0]  hist_bin;
    logic [17:0] hist_count;
    logic        hist_last;
    logic        busy;
    logic        sat_flag;
    logic        pixel_drop;
    logic        frame_overrun;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [17:0] pre_data;
    logic [17:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;
    int got [256];
    int exp_cnt [256];
    int bad_order, bad_stable, bad_last;

    hist_frame_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(18)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .VSYNC         (VSYNC),
        .DataEn        (DataEn),
        .PixelData     (PixelData),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .ram_we        (ram_we),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .hist_valid    (hist_valid),
        .hist_ready    (hist_ready),
        .hist_bin      (hist_bin),
        .hist_count    (hist_count),
        .hist_last     (hist_last),
        .busy          (busy),
        .sat_flag      (sat_flag),
        .pixel_drop    (pixel_drop),
        .frame_overrun (frame_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle read-first RAM; pre_* lets the bench preload a bin.
    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr]    <= pre_data;
        else if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_exp;
        for (int i = 0; i < 256; i++) exp_cnt[i] = 0;
    endtask

    task automatic frame_cmp(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < 256; i++) if (got[i] != exp_cnt[i]) diffs++;
        chk(tag, diffs, 0);
    endtask

    task automatic mem_zero(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 18'd0) nz++;
        chk(tag, nz, 0);
    endtask

    // Collect one full readout starting in the DUMP_RD cycle.
    task automatic run_dump(input bit stall, input bit inject, output int cyc);
        int          nb;
        logic        pv;
        logic [7:0]  pb;
        logic [17:0] pc;
        nb = 0; cyc = 0; pv = 1'b0; pb = '0; pc = '0;
        bad_order = 0; bad_stable = 0; bad_last = 0;
        for (int i = 0; i < 256; i++) got[i] = -1;
        while (nb < 256 && cyc < 4000) begin
            hist_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (inject) begin
                if (cyc == 20) begin DataEn = 1'b1; PixelData = 8'd5; end
                if (cyc == 21) DataEn = 1'b0;
                if (cyc == 40) VSYNC = 1'b0;
                if (cyc == 41) VSYNC = 1'b1;
            end
            #1;
            if (inject && cyc == 20) chk("drop_pulse", pixel_drop, 1);
            if (inject && cyc == 21) chk("drop_idle", pixel_drop, 0);
            if (inject && cyc == 41) chk("overrun_pulse", frame_overrun, 1);
            if (inject && cyc == 42) chk("overrun_idle", frame_overrun, 0);
            if (pv && (hist_valid !== 1'b1 || hist_bin !== pb || hist_count !== pc)) bad_stable++;
            if (hist_last !== (hist_valid && hist_bin == 8'd255)) bad_last++;
            pv = hist_valid && !hist_ready;
            pb = hist_bin;
            pc = hist_count;
            if (hist_valid && hist_ready) begin
                if (hist_bin !== nb[7:0]) bad_order++;
                if (hist_last !== (nb == 255)) bad_last++;
                got[nb] = int'(hist_count);
                nb++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        hist_ready = 1'b1;
        chk("dump_bins", nb, 256);
        chk("dump_order", bad_order, 0);
        chk("dump_last", bad_last, 0);
        chk("dump_stable", bad_stable, 0);
    endtask

    initial begin
        int bad, n, cyc;
        rst_n = 1'b0; VSYNC = 1'b0; DataEn = 1'b0; PixelData = '0;
        hist_ready = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset state
        #12;
        chk("reset_outs", {busy, ram_we, hist_valid, sat_flag, pixel_drop, frame_overrun,
                           hist_last, ram_rd_addr, ram_wr_addr}, 0);

        // Clear sweep: 256 zero writes, busy rises after first clk
        #8 rst_n = 1'b1;
        #1;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (!(ram_we === 1'b1 && ram_wr_addr === k[7:0] && ram_wr_data === 18'd0)) bad++;
            if (k == 0) chk("busy_first_cycle", busy, 0);
            if (k == 1) chk("busy_clear", busy, 1);
            step;
        end
        chk("clear_writes", bad, 0);
        chk("busy_after_clear", {busy, ram_we}, 0);
        PixelData = 8'hA5;
        #1;
        chk("accum_rd_addr", ram_rd_addr, 8'hA5);

        // Frame 1: 5,5,5 then 7 together with VSYNC rise
        DataEn = 1'b1; PixelData = 8'd5;
        step;
        chk("fwd_w1", {ram_we, ram_wr_addr, ram_wr_data}, {1'b1, 8'd5, 18'd1});
        step;
        chk("fwd_w2", {ram_we, ram_wr_addr, ram_wr_data}, {1'b1, 8'd5, 18'd2});
        step;
        PixelData = 8'd7; VSYNC = 1'b1;
        #1;
        chk("fwd_w3", {ram_we, ram_wr_addr, ram_wr_data}, {1'b1, 8'd5, 18'd3});
        chk("accum_no_flags", {frame_overrun, pixel_drop}, 0);
        step;
        DataEn = 1'b0;
        #1;
        chk("drain_write", {ram_we, ram_wr_addr, ram_wr_data}, {1'b1, 8'd7, 18'd1});
        chk("drain_busy", {busy, hist_valid}, 2'b10);
        step;
        run_dump(1'b0, 1'b0, cyc);
        chk("dump_cycles", cyc, 512);
        chk("f1_bin5", got[5], 3);
        chk("f1_bin7", got[7], 1);
        clr_exp; exp_cnt[5] = 3; exp_cnt[7] = 1;
        frame_cmp("f1_all_bins");
        chk("busy_after_dump", busy, 0);

        // Frame 2: stalled readout with drop/overrun injection
        VSYNC = 1'b0;
        step;
        DataEn = 1'b1; PixelData = 8'd255; step;
        step;
        PixelData = 8'd0; step;
        PixelData = 8'd3; step;
        DataEn = 1'b0; step;
        DataEn = 1'b1; step;
        DataEn = 1'b0; step;
        step;
        VSYNC = 1'b1; step;
        step;
        run_dump(1'b1, 1'b1, cyc);
        clr_exp; exp_cnt[255] = 2; exp_cnt[0] = 1; exp_cnt[3] = 2;
        chk("f2_bin255", got[255], 2);
        frame_cmp("f2_all_bins");
        mem_zero("f2_ram_zero");

        // Saturation
        VSYNC = 1'b0;
        pre_we = 1'b1; pre_addr = 8'd9; pre_data = 18'h3FFFF;
        step;
        pre_we = 1'b0;
        chk("sat_pre", sat_flag, 0);
        DataEn = 1'b1; PixelData = 8'd9;
        step;
        chk("sat_w1", {ram_we, ram_wr_addr, ram_wr_data}, {1'b1, 8'd9, 18'h3FFFF});
        step;
        DataEn = 1'b0;
        #1;
        chk("sat_w2", {ram_we, ram_wr_addr, ram_wr_data}, {1'b1, 8'd9, 18'h3FFFF});
        chk("sat_set", sat_flag, 1);
        step;
        VSYNC = 1'b1; step;
        step;
        chk("sat_hold_dump", sat_flag, 1);
        run_dump(1'b0, 1'b0, cyc);
        chk("sat_bin9", got[9], 18'h3FFFF);
        clr_exp; exp_cnt[9] = 18'h3FFFF;
        frame_cmp("f3_all_bins");
        chk("sat_cleared", sat_flag, 0);

        // Reset in the middle of a readout
        VSYNC = 1'b0; step;
        DataEn = 1'b1; PixelData = 8'd200; step;
        DataEn = 1'b0; step;
        VSYNC = 1'b1; step;
        step;
        hist_ready = 1'b1;
        n = 0;
        while (!(hist_valid === 1'b1 && hist_bin === 8'd100) && n < 1000) begin
            step;
            n++;
        end
        chk("reach_bin100", {hist_valid, hist_bin}, {1'b1, 8'd100});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dump", {hist_valid, busy, ram_we, hist_bin, hist_count, hist_last,
                             sat_flag}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("restart_bin0", {ram_we, ram_wr_addr, busy}, {1'b1, 8'd0, 1'b0});
        step;
        chk("restart_bin1", {ram_we, ram_wr_addr, busy}, {1'b1, 8'd1, 1'b1});
        n = 1;
        while (busy === 1'b1 && n < 600) begin
            step;
            n++;
        end
        chk("restart_clear_len", n, 256);
        mem_zero("restart_ram_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
